// File: rtl/border_cropper.sv
// border_cropper: strips the symmetric-extension border words from each line
// coming out of the DWT97 line filter. The first Head words of a line are
// discarded, the rest pass through a (Tail+1)-deep shift buffer so the last
// Tail words can be dropped once the line's eol is seen. sof is regenerated on
// the first kept word of a frame, eol on the last kept word of each line.
// Optional macro BORDER_CROPPER_ERR_EN: enables the err_o short-line pulse;
// without it err_o is tied low and short lines are dropped silently.
module border_cropper #(
  parameter int DataWidth = 8,
  parameter int Head      = 4,
  parameter int Tail      = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  output logic                   s_ready_o,
  input  logic                   s_valid_i,
  input  logic                   s_sof_i,
  input  logic                   s_eol_i,
  input  logic [2*DataWidth-1:0] s_data_i,
  input  logic                   m_ready_i,
  output logic                   m_valid_o,
  output logic                   m_sof_o,
  output logic                   m_eol_o,
  output logic [2*DataWidth-1:0] m_data_o,
  output logic                   err_o
);

  localparam int W     = 2 * DataWidth;
  localparam int Depth = Tail + 1;
  localparam int HcW   = $clog2(Head + 1);
  localparam int CntW  = $clog2(Depth + 1);
  localparam int IdxW  = $clog2(Depth);

  typedef enum logic {ST_HEAD, ST_FILL} state_e;

  typedef struct packed {
    logic         eol;
    logic [W-1:0] data;
  } entry_t;

  state_e                 state_q;
  logic [HcW-1:0]         head_cnt_q;
  logic [CntW-1:0]        cnt_q;
  entry_t [Depth-1:0]     sr_q;       // [0] oldest, [cnt_q-1] newest
  logic                   sof_pend_q;

  logic            full, newest_eol;
  logic            s_fire, m_fire, line_end;
  logic            restart, in_head, head_word, push, short_line;
  logic [HcW-1:0]  hc_base, hc_next;
  logic [IdxW-1:0] widx;

  // Handshake, output and line-event decode.
  always_comb begin
    full       = (cnt_q == CntW'(Depth));
    // An eol can only sit in the buffer when it is full: shorter lines are
    // flushed the moment their eol is pushed.
    newest_eol = full & sr_q[Depth-1].eol;
    s_ready_o  = !rst_i & ((state_q == ST_HEAD) | (!newest_eol & (!full | m_ready_i)));
    m_valid_o  = (state_q == ST_FILL) & full;
    m_data_o   = m_valid_o ? sr_q[0].data : '0;
    m_eol_o    = m_valid_o & sr_q[Depth-1].eol;
    m_sof_o    = m_valid_o & sof_pend_q;

    s_fire     = s_valid_i & s_ready_o;
    m_fire     = m_valid_o & m_ready_i;
    line_end   = m_fire & m_eol_o;

    // A sof arriving anywhere but the very first head slot breaks the current
    // line; the word restarts the head count as word 1 of a new line.
    restart    = s_fire & s_sof_i & ((state_q == ST_FILL) | (head_cnt_q != '0));
    in_head    = (state_q == ST_HEAD) | restart;
    head_word  = s_fire & in_head;
    push       = s_fire & !in_head;
    hc_base    = restart ? '0 : head_cnt_q;
    hc_next    = hc_base + HcW'(1);

    // Short line: eol while still counting head words, or an eol push that
    // leaves the buffer below Tail+1 entries (no pop possible then).
    short_line = s_fire & s_eol_i & (in_head | (!m_fire & (cnt_q < CntW'(Tail))));

    widx       = m_fire ? IdxW'(cnt_q - CntW'(1)) : IdxW'(cnt_q);
  end

  // Head counting, buffer shifting, line termination and sof tracking.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_HEAD;
      head_cnt_q <= '0;
      cnt_q      <= '0;
      sr_q       <= '0;
      sof_pend_q <= 1'b0;
    end else begin
      if (m_fire) sof_pend_q <= 1'b0;
      if (s_fire & s_sof_i) sof_pend_q <= 1'b1;

      if (short_line | line_end) begin
        // Line over: the Tail border words still buffered are discarded.
        state_q    <= ST_HEAD;
        head_cnt_q <= '0;
        cnt_q      <= '0;
      end else if (head_word) begin
        cnt_q      <= '0;
        head_cnt_q <= hc_next;
        state_q    <= (hc_next == HcW'(Head)) ? ST_FILL : ST_HEAD;
      end else begin
        if (m_fire) begin
          for (int i = 0; i < Depth - 1; i++) sr_q[i] <= sr_q[i+1];
        end
        if (push) sr_q[widx] <= '{eol: s_eol_i, data: s_data_i};
        cnt_q <= cnt_q + CntW'(push) - CntW'(m_fire);
      end
    end
  end

`ifdef BORDER_CROPPER_ERR_EN
  logic err_q;

  // One-cycle pulse for every dropped short line.
  always_ff @(posedge clk_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= short_line;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_border_cropper.sv
// tb_border_cropper: directed scenarios with randomized handshakes, checked
// against a line-level reference model (drop Head/Tail words per line).
module tb_border_cropper;

  localparam int DW = 8;
  localparam int HD = 4;
  localparam int TL = 4;
  localparam int W  = 2 * DW;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         s_ready_o, s_valid_i, s_sof_i, s_eol_i;
  logic [W-1:0] s_data_i;
  logic         m_ready_i, m_valid_o, m_sof_o, m_eol_o, err_o;
  logic [W-1:0] m_data_o;

  border_cropper #(.DataWidth(DW), .Head(HD), .Tail(TL)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .s_ready_o (s_ready_o),
    .s_valid_i (s_valid_i),
    .s_sof_i   (s_sof_i),
    .s_eol_i   (s_eol_i),
    .s_data_i  (s_data_i),
    .m_ready_i (m_ready_i),
    .m_valid_o (m_valid_o),
    .m_sof_o   (m_sof_o),
    .m_eol_o   (m_eol_o),
    .m_data_o  (m_data_o),
    .err_o     (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic         sof;
    logic         eol;
    logic [W-1:0] data;
  } word_t;

  word_t in_q[$];
  word_t exp_q[$];
  word_t got_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  bit    model_sofp = 1'b0;
  int    exp_short, got_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic add_word(input int val, input bit sof, input bit eol);
    word_t w;
    w.sof  = sof;
    w.eol  = eol;
    w.data = W'(val);
    in_q.push_back(w);
  endtask

  task automatic add_ramp(input int lo, input int hi, input bit sof, input bit eol);
    for (int v = lo; v <= hi; v++) add_word(v, sof && (v == lo), eol && (v == hi));
  endtask

  // Reference: a line keeps words Head .. len-Tail-1. A closed line shorter than
  // Head+Tail+1 is dropped whole; a trailing unterminated line has emitted the
  // words that already have Tail successors.
  task automatic emit(input word_t line[$], input bit closed);
    int hi;
    if (line[0].sof) model_sofp = 1'b1;
    if (closed && line.size() < HD + TL + 1) begin
      exp_short++;
      return;
    end
    hi = line.size() - TL;
    for (int k = HD; k < hi; k++) begin
      word_t w;
      w.data = line[k].data;
      w.eol  = closed && (k == hi - 1);
      w.sof  = model_sofp;
      model_sofp = 1'b0;
      exp_q.push_back(w);
    end
  endtask

  task automatic model_stream();
    word_t line[$];
    foreach (in_q[i]) begin
      line.push_back(in_q[i]);
      if (in_q[i].eol) begin
        emit(line, 1'b1);
        line.delete();
      end
    end
    if (line.size() != 0) emit(line, 1'b0);
  endtask

  // Drive in_q with pv% valid and pr% ready, collect outputs, compare to model.
  task automatic run(input string name, input int pv, input int pr, input bit chk_lat);
    int    idx = 0, cyc = 0, idle = 0, lat_acc = -1, lat_out = -1, n;
    bit    stall = 1'b0;
    word_t held, cur;
    exp_q.delete();
    got_q.delete();
    exp_short = 0;
    got_err   = 0;
    model_stream();
    while (idle < 40 && cyc < 4000) begin
      @(negedge clk_i);
      if (idx < in_q.size() && $urandom_range(99) < pv) begin
        s_valid_i = 1'b1;
        {s_sof_i, s_eol_i, s_data_i} = in_q[idx];
      end else begin
        s_valid_i = 1'b0;
        s_sof_i   = 1'b0;
        s_eol_i   = 1'b0;
        s_data_i  = W'($urandom);
      end
      m_ready_i = ($urandom_range(99) < pr);
      #2;
      cur = {m_sof_o, m_eol_o, m_data_o};
      if (stall) begin
        chk({name, " hold_valid"}, m_valid_o, 1);
        chk({name, " hold_word"}, cur, held);
      end
      if (err_o) got_err++;
      if (s_valid_i && s_ready_o) begin
        if (idx == HD + TL) lat_acc = cyc;
        idx++;
      end
      if (m_valid_o) begin
        if (lat_out < 0) lat_out = cyc;
        if (m_ready_i) got_q.push_back(cur);
      end
      stall = m_valid_o && !m_ready_i;
      held  = cur;
      if (idx == in_q.size()) idle++;
      cyc++;
    end
    s_valid_i = 1'b0;
    s_sof_i   = 1'b0;
    s_eol_i   = 1'b0;
    m_ready_i = 1'b0;
    chk({name, " inputs_accepted"}, idx, in_q.size());
    chk({name, " out_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s data[%0d]", name, i), got_q[i].data, exp_q[i].data);
      chk($sformatf("%s sof[%0d]", name, i), got_q[i].sof, exp_q[i].sof);
      chk($sformatf("%s eol[%0d]", name, i), got_q[i].eol, exp_q[i].eol);
    end
`ifdef BORDER_CROPPER_ERR_EN
    chk({name, " err_pulses"}, got_err, exp_short);
`else
    chk({name, " err_pulses"}, got_err, 0);
`endif
    if (chk_lat) chk({name, " first_latency"}, lat_out - lat_acc, 1);
  endtask

  int rt[16] = '{5, 4, 3, 2, 1, 2, 3, 4, 5, 6, 7, 8, 7, 6, 5, 4};

  initial begin
    rst_i     = 1'b1;
    s_valid_i = 1'b0;
    s_sof_i   = 1'b0;
    s_eol_i   = 1'b0;
    s_data_i  = '0;
    m_ready_i = 1'b0;

    // Reset state
    repeat (2) @(negedge clk_i);
    #2;
    chk("rst s_ready", s_ready_o, 0);
    chk("rst m_valid", m_valid_o, 0);
    chk("rst m_data", m_data_o, 0);
    chk("rst m_sof", m_sof_o, 0);
    chk("rst m_eol", m_eol_o, 0);
    chk("rst err", err_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #2;
    chk("post_rst s_ready", s_ready_o, 1);
    model_sofp = 1'b0;

    // Round trip, always ready
    in_q.delete();
    foreach (rt[i]) add_word(rt[i], i == 0, i == 15);
    run("roundtrip", 100, 100, 1'b1);

    // Same line with random handshakes
    in_q.delete();
    foreach (rt[i]) add_word(rt[i], i == 0, i == 15);
    run("roundtrip_rand", 50, 50, 1'b0);

    // Two consecutive lines, sof only on the first
    in_q.delete();
    add_ramp(1, 16, 1'b1, 1'b1);
    add_ramp(17, 32, 1'b0, 1'b1);
    run("two_lines", 70, 60, 1'b0);

    // Minimum-length line
    in_q.delete();
    add_ramp(1, 9, 1'b1, 1'b1);
    run("min_line", 100, 100, 1'b0);

    // Short line then a normal line; sof carries over
    in_q.delete();
    add_ramp(1, 8, 1'b1, 1'b1);
    add_ramp(101, 116, 1'b0, 1'b1);
    run("short_line", 60, 80, 1'b0);

    // Random line lengths around the short/long boundary
    in_q.delete();
    for (int l = 0; l < 6; l++) begin
      int len = $urandom_range(6, 20);
      for (int i = 0; i < len; i++) add_word($urandom_range(255), (l == 0) && (i == 0), i == len - 1);
    end
    run("rand_lines", 50, 50, 1'b0);

    // Reset mid-line: 10 words of an unterminated line, then reset
    in_q.delete();
    add_ramp(1, 10, 1'b1, 1'b0);
    run("pre_reset", 100, 100, 1'b0);
    @(negedge clk_i);
    rst_i     = 1'b1;
    m_ready_i = 1'b1;
    #2;
    chk("midrst s_ready", s_ready_o, 0);
    @(negedge clk_i);
    rst_i     = 1'b0;
    m_ready_i = 1'b0;
    model_sofp = 1'b0;
    #2;
    chk("midrst m_valid", m_valid_o, 0);
    chk("midrst s_ready", s_ready_o, 1);
    in_q.delete();
    add_ramp(201, 216, 1'b1, 1'b1);
    run("post_reset", 80, 70, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
